mole_pacer: RTL



---
 rtl/whack_pkg.sv | 37 +++
 rtl/pace_counter.sv | 56 +++++
 rtl/mole_pacer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/whack_pkg.sv
`default_nettype none
// ============================================================================
// Package  : whack_pkg
// Purpose  : Shared types, constants and helpers for the whack-a-mole game
//            blocks (mole pacing state encoding, segment range, segment
//            selection helper).
// Contents : pacer_state_t  - mole pacer state encoding (2-bit)
//            SEG_COUNT      - number of usable 7-seg segments (0..6)
//            SEG_INVALID    - the one 3-bit code that is not a segment
//            pick_seg()     - maps an LFSR candidate to a legal segment that
//                             differs from the previous mole's segment
// Revision : 1.0 - initial release
// ============================================================================
package whack_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GAP  = 2'd1,
      UP   = 2'd2
   } pacer_state_t;

   localparam int         SEG_COUNT   = 7;
   localparam logic [2:0] SEG_INVALID = 3'd7;

   // Fold the unused code 7 onto segment 0, then step forward (wrapping
   // 6 -> 0) if the result would repeat the previous mole's segment.
   function automatic logic [2:0] pick_seg(input logic [2:0] cand_raw,
                                           input logic [2:0] prev_seg);
      logic [2:0] w_cand;
      w_cand = (cand_raw == SEG_INVALID) ? 3'd0 : cand_raw;
      if (w_cand == prev_seg)
         w_cand = (w_cand == 3'(SEG_COUNT - 1)) ? 3'd0 : w_cand + 3'd1;
      return w_cand;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pace_counter.sv
`default_nettype none
// ============================================================================
// Module   : pace_counter
// Purpose  : Loadable down-counter that times both the dark gap and the
//            visible window of a mole. Counts down to zero and stops there.
//            is_one is registered and reports that the count now held is 1,
//            so the owner can act on the final cycle without a comparator
//            in its own path.
// Ports    : clk      - system clock
//            rst_n    - asynchronous active-low reset
//            load     - load load_val this edge (has priority over en)
//            load_val - value to load
//            en       - decrement this edge (ignored at zero)
//            is_one   - registered flag: count == 1
// Revision : 1.0 - initial release
// ============================================================================
module pace_counter
   import whack_pkg::*;
#(
   parameter int unsigned WIN_W = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIN_W-1:0] load_val,
   input  logic             en,
   output logic             is_one
);

   localparam logic [WIN_W-1:0] c_ONE = {{(WIN_W-1){1'b0}}, 1'b1};

   logic [WIN_W-1:0] r_count;
   logic [WIN_W-1:0] w_count_nxt;

   always_comb begin
      w_count_nxt = r_count;
      if (load)
         w_count_nxt = load_val;
      else if (en && (r_count != '0))
         w_count_nxt = r_count - c_ONE;
   end

   // is_one is derived from the next count so it is valid in the same
   // cycle that the count itself holds 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
         is_one  <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         is_one  <= (w_count_nxt == c_ONE);
      end
   end

endmodule
`default_nettype wire

// File: rtl/mole_pacer.sv
`default_nettype none
// ============================================================================
// Module   : mole_pacer
// Purpose  : Sequences mole appearances: dark gap, then a visible window on a
//            chosen segment, ended by a correct hit or a timeout (miss).
//            Every HITS_PER_LEVEL hits raise the level and shorten the
//            window toward MIN_WINDOW. Dropping run returns to IDLE while
//            keeping level/miss count/window for score display.
// Ports    : clk        - system clock
//            rst_n      - asynchronous active-low reset
//            run        - game active
//            rand_in    - LFSR segment candidate (sampled every cycle)
//            hit        - one-cycle pulse: correct button pressed
//            mole_valid - mole currently displayed
//            mole_seg   - active mole segment 0..6
//            miss_pulse - one-cycle pulse: window expired unhit
//            level      - current difficulty level
//            miss_cnt   - misses this game, saturating at 15
//            window_cur - visible window currently in force (cycles)
// Revision : 1.0 - initial release
// ============================================================================
module mole_pacer
   import whack_pkg::*;
#(
   parameter int unsigned      WIN_W          = 24,
   parameter logic [WIN_W-1:0] BASE_WINDOW    = 24'd6_000_000,
   parameter logic [WIN_W-1:0] WINDOW_STEP    = 24'd500_000,
   parameter logic [WIN_W-1:0] MIN_WINDOW     = 24'd1_500_000,
   parameter logic [WIN_W-1:0] GAP_CYCLES     = 24'd500_000,
   parameter int unsigned      HITS_PER_LEVEL = 3,
   parameter int unsigned      MAX_LEVEL      = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic [2:0]       rand_in,
   input  logic             hit,
   output logic             mole_valid,
   output logic [2:0]       mole_seg,
   output logic             miss_pulse,
   output logic [2:0]       level,
   output logic [3:0]       miss_cnt,
   output logic [WIN_W-1:0] window_cur
);

   // One extra bit so MIN_WINDOW + WINDOW_STEP cannot wrap.
   localparam logic [WIN_W:0] c_STEP_THRESH = {1'b0, MIN_WINDOW} + {1'b0, WINDOW_STEP};
   localparam logic [3:0]     c_HITS_TARGET = 4'(HITS_PER_LEVEL);
   localparam logic [2:0]     c_LEVEL_MAX   = 3'(MAX_LEVEL);
   localparam logic [3:0]     c_MISS_SAT    = 4'hF;

   pacer_state_t     r_state;
   logic [3:0]       r_hit_cnt;

   logic             w_cnt_is_one;
   logic             w_cnt_load;
   logic             w_cnt_en;
   logic [WIN_W-1:0] w_cnt_val;
   logic [3:0]       w_hit_nxt;
   logic [WIN_W-1:0] w_window_dn;
   logic [2:0]       w_seg_pick;

   // ---------------------------------------------------------------------
   // Shared gap/window timer
   // ---------------------------------------------------------------------
   pace_counter #(
      .WIN_W (WIN_W)
   ) u_pace_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (w_cnt_load),
      .load_val (w_cnt_val),
      .en       (w_cnt_en),
      .is_one   (w_cnt_is_one)
   );

   // The timer is reloaded on every state change into GAP or UP; its value
   // outside those states is never used, so a dropped run needs no reload.
   always_comb begin
      w_cnt_load = 1'b0;
      w_cnt_val  = GAP_CYCLES;
      w_cnt_en   = (r_state == GAP) || (r_state == UP);
      case (r_state)
         IDLE: w_cnt_load = run;
         GAP: begin
            if (run && w_cnt_is_one) begin
               w_cnt_load = 1'b1;
               w_cnt_val  = window_cur;
            end
         end
         UP:      w_cnt_load = run && (hit || w_cnt_is_one);
         default: w_cnt_load = 1'b0;
      endcase
   end

   assign w_hit_nxt   = r_hit_cnt + 4'd1;
   // Compare before subtracting: never underflows, lands exactly on the floor.
   assign w_window_dn = ({1'b0, window_cur} < c_STEP_THRESH) ? MIN_WINDOW
                                                             : window_cur - WINDOW_STEP;
   assign w_seg_pick  = pick_seg(rand_in, mole_seg);

   // ---------------------------------------------------------------------
   // Pacing FSM with registered outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_hit_cnt  <= 4'd0;
         mole_valid <= 1'b0;
         mole_seg   <= 3'd0;
         miss_pulse <= 1'b0;
         level      <= 3'd0;
         miss_cnt   <= 4'd0;
         window_cur <= BASE_WINDOW;
      end else begin
         miss_pulse <= 1'b0;
         if (!run) begin
            // Score registers hold so the display can show the result.
            r_state    <= IDLE;
            mole_valid <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  level      <= 3'd0;
                  miss_cnt   <= 4'd0;
                  r_hit_cnt  <= 4'd0;
                  window_cur <= BASE_WINDOW;
                  r_state    <= GAP;
               end
               GAP: begin
                  if (w_cnt_is_one) begin
                     r_state    <= UP;
                     mole_valid <= 1'b1;
                     mole_seg   <= w_seg_pick;
                  end
               end
               UP: begin
                  // A hit on the final window cycle beats the timeout.
                  if (hit) begin
                     mole_valid <= 1'b0;
                     r_state    <= GAP;
                     if (w_hit_nxt == c_HITS_TARGET) begin
                        r_hit_cnt <= 4'd0;
                        if (level < c_LEVEL_MAX) begin
                           level      <= level + 3'd1;
                           window_cur <= w_window_dn;
                        end
                     end else begin
                        r_hit_cnt <= w_hit_nxt;
                     end
                  end else if (w_cnt_is_one) begin
                     miss_pulse <= 1'b1;
                     mole_valid <= 1'b0;
                     r_state    <= GAP;
                     if (miss_cnt != c_MISS_SAT)
                        miss_cnt <= miss_cnt + 4'd1;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

endmodule
`default_nettype wire
